// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// Holds the per-stage control payload, configuration check and group P/G reduction.
package cla_pkg;

   // Operand and partial-sum vectors live beside this record in the top level.
   typedef struct packed {
      logic valid;
      logic sub;
      logic carry;
   } stage_ctl_t;

   localparam int unsigned MAX_GROUP = 64;

   function automatic bit cfg_ok(input int unsigned w, input int unsigned s, input int unsigned g);
      if (w == 0 || s == 0 || g == 0 || s > w || g > MAX_GROUP) return 1'b0;
      if ((w % s) != 0) return 1'b0;
      return ((w / s) % g) == 0;
   endfunction

   // Returns {group propagate, group generate} over the low n bits.
   function automatic logic [1:0] group_pg(input logic [63:0] p, input logic [63:0] g,
                                           input int unsigned n);
      logic pp;
      logic gg;
      pp = 1'b1;
      gg = 1'b0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (i < n) begin
            gg = g[i] | (p[i] & gg);
            pp = pp & p[i];
         end
      end
      return {pp, gg};
   endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead adder for one pipeline slice.
// Group carries are resolved from group P/G; bit carries ripple only inside a group.
module cla_slice
   import cla_pkg::*;
#(
   parameter int unsigned SW    = 4,
   parameter int unsigned GROUP = 4
)(
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          cin,
   output logic [SW-1:0] sum,
   output logic          cout
);

   localparam int unsigned NG = SW / GROUP;

   logic [SW-1:0] p;
   logic [SW-1:0] g;
   logic [SW:0]   c;
   logic [1:0]    pg;

   always_comb begin
      p     = a ^ b;
      g     = a & b;
      c     = '0;
      c[0]  = cin;
      pg    = '0;
      for (int unsigned j = 0; j < NG; j++) begin
         for (int unsigned i = 1; i < GROUP; i++) begin
            c[j*GROUP + i] = g[j*GROUP + i - 1] | (p[j*GROUP + i - 1] & c[j*GROUP + i - 1]);
         end
         pg = group_pg(64'(p[j*GROUP +: GROUP]), 64'(g[j*GROUP +: GROUP]), GROUP);
         c[(j+1)*GROUP] = pg[0] | (pg[1] & c[j*GROUP]);
      end
      sum  = p ^ c[SW-1:0];
      cout = c[SW];
   end

endmodule

// File: rtl/cla_add_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Stage k adds slice k-1; finished sum bits travel with the word to the output.
module cla_add_pipe
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2,
   parameter int unsigned GROUP  = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic             out_ovf
);

   localparam int unsigned SW = WIDTH / STAGES;

   if (!cfg_ok(WIDTH, STAGES, GROUP)) begin : g_cfg_err
      $error("cla_add_pipe: WIDTH must be a multiple of STAGES and WIDTH/STAGES a multiple of GROUP");
   end

   stage_ctl_t       ctl_q [1:STAGES];
   logic [WIDTH-1:0] a_q   [1:STAGES];
   logic [WIDTH-1:0] b_q   [1:STAGES];
   logic [WIDTH-1:0] s_q   [1:STAGES];

   stage_ctl_t       ctl_in [0:STAGES-1];
   logic [WIDTH-1:0] a_in   [0:STAGES-1];
   logic [WIDTH-1:0] b_in   [0:STAGES-1];
   logic [WIDTH-1:0] s_in   [0:STAGES-1];

   logic [SW-1:0]     ss [0:STAGES-1];
   logic [STAGES-1:0] sco;
   logic [STAGES+1:1] adv;

   // Source of stage k+1: the input port for the first stage, else stage k's registers.
   always_comb begin
      ctl_in[0] = '{valid: in_valid, sub: in_sub, carry: in_sub | in_cin};
      a_in[0]   = in_a;
      b_in[0]   = in_b;
      s_in[0]   = '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
         ctl_in[k] = ctl_q[k];
         a_in[k]   = a_q[k];
         b_in[k]   = b_q[k];
         s_in[k]   = s_q[k];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      cla_slice #(.SW(SW), .GROUP(GROUP)) u_slice (
         .a    (a_in[k][k*SW +: SW]),
         .b    (b_in[k][k*SW +: SW] ^ {SW{ctl_in[k].sub}}),
         .cin  (ctl_in[k].carry),
         .sum  (ss[k]),
         .cout (sco[k])
      );
   end

   // An empty stage always loads, so bubbles collapse under a downstream stall.
   always_comb begin
      adv = '0;
      adv[STAGES+1] = out_ready;
      for (int unsigned k = STAGES; k >= 1; k--) begin
         adv[k] = !ctl_q[k].valid || adv[k+1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 1; k <= STAGES; k++) begin
            ctl_q[k] <= '0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            s_q[k]   <= '0;
         end
      end else begin
         for (int unsigned k = 1; k <= STAGES; k++) begin
            if (adv[k]) begin
               ctl_q[k] <= '{valid: ctl_in[k-1].valid, sub: ctl_in[k-1].sub, carry: sco[k-1]};
               a_q[k]   <= a_in[k-1];
               b_q[k]   <= b_in[k-1];
               s_q[k]   <= s_in[k-1];
               s_q[k][(k-1)*SW +: SW] <= ss[k-1];
            end
         end
      end
   end

   logic a_msb;
   logic b_msb;
   logic s_msb;

   assign a_msb     = a_q[STAGES][WIDTH-1];
   assign b_msb     = b_q[STAGES][WIDTH-1] ^ ctl_q[STAGES].sub;
   assign s_msb     = s_q[STAGES][WIDTH-1];

   assign in_ready  = adv[1];
   assign out_valid = ctl_q[STAGES].valid;
   assign out_sum   = {ctl_q[STAGES].carry, s_q[STAGES]};
   assign out_ovf   = (a_msb == b_msb) && (s_msb != a_msb);

endmodule

// File: tb/tb_cla_add_pipe.sv
// Self-checking bench for cla_add_pipe (WIDTH=8, STAGES=2) against an arithmetic model.
// Directed vectors, backpressure, mid-flight reset and random valid/ready traffic.
module tb_cla_add_pipe;

   localparam int unsigned W  = 8;
   localparam int unsigned ST = 2;
   localparam int unsigned GR = 4;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a      = '0;
   logic [W-1:0] in_b      = '0;
   logic         in_cin    = 1'b0;
   logic         in_sub    = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W:0]   out_sum;
   logic         out_ovf;

   int checks = 0;
   int errors = 0;
   int n_acc  = 0;

   logic [W+1:0] expq[$];
   logic         held = 1'b0;
   logic [W+1:0] held_val;
   logic [W+1:0] e;

   cla_add_pipe #(.WIDTH(W), .STAGES(ST), .GROUP(GR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Returns {carry, sum, ovf} from plain integer arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint lim = longint'(1) << W;
      longint r;
      longint sr;
      logic   carry;
      logic   ovf;
      logic [W-1:0] s;
      if (sub) begin
         r     = ua - ub;
         carry = (ua >= ub);
         sr    = sa - sb;
      end else begin
         r     = ua + ub + longint'(cin);
         carry = (r >= lim);
         sr    = sa + sb + longint'(cin);
      end
      s   = W'(r);
      ovf = (sr >= lim / 2) || (sr < -(lim / 2));
      return {carry, s, ovf};
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         expq.delete();
         held = 1'b0;
      end else begin
         if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'({out_sum, out_ovf}), 32'(held_val));
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               chk("unexpected_output", 32'(expq.size()), 32'd1);
            end else begin
               e = expq.pop_front();
               chk("result", 32'({out_sum, out_ovf}), 32'(e));
            end
         end
         held     = out_valid && !out_ready;
         held_val = {out_sum, out_ovf};
         if (in_valid && in_ready) begin
            expq.push_back(model(in_a, in_b, in_cin, in_sub));
            n_acc++;
         end
      end
   end

   // Presents one word; returns 1 time unit after the edge that accepted it.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      bit fire;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_sub   = sub;
      in_valid = 1'b1;
      fire     = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            fire = 1'b1;
            break;
         end
      end
      if (!fire) chk("send_timeout", 32'(fire), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub,
                                 input logic [W:0] exp_sum, input logic exp_ovf);
      send(a, b, cin, sub);
      chk({name, "_early"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_sum"},   32'(out_sum),   32'(exp_sum));
      chk({name, "_ovf"},   32'(out_ovf),   32'(exp_ovf));
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40; i++) begin
         if (expq.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk(name, 32'(expq.size()), 32'd0);
   endtask

   initial begin
      int base;
      bit got;
      bit fired;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum",   32'(out_sum),   32'd0);
      chk("rst_out_ovf",   32'(out_ovf),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      rst_n = 1'b1;

      chk("model_add_wrap", 32'(model(8'hFF, 8'h01, 1'b0, 1'b0)), 32'({9'h100, 1'b0}));
      chk("model_add_ovf",  32'(model(8'h7F, 8'h01, 1'b0, 1'b0)), 32'({9'h080, 1'b1}));
      chk("model_sub_brw",  32'(model(8'h05, 8'h07, 1'b0, 1'b1)), 32'({9'h0FE, 1'b0}));
      chk("model_sub_ovf",  32'(model(8'h80, 8'h01, 1'b0, 1'b1)), 32'({9'h17F, 1'b1}));
      chk("model_add_cin",  32'(model(8'h10, 8'h20, 1'b1, 1'b0)), 32'({9'h031, 1'b0}));

      @(posedge clk);
      #1;
      send_and_check("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b0);
      send_and_check("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 1'b1);
      send_and_check("sub_brw",  8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE, 1'b0);
      send_and_check("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, 9'h17F, 1'b1);
      send_and_check("sub_cin",  8'h40, 8'h10, 1'b1, 1'b1, 9'h130, 1'b0);
      drain("drain_directed");

      // Backpressure: four words with the consumer stalled.
      base = n_acc;
      out_ready = 1'b0;
      fork
         begin
            send(8'h12, 8'h34, 1'b0, 1'b0);
            send(8'hC8, 8'h64, 1'b1, 1'b0);
            send(8'h01, 8'h02, 1'b0, 1'b1);
            send(8'h90, 8'h90, 1'b0, 1'b0);
         end
         begin
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
               @(posedge clk);
               #2;
               if (n_acc >= base + 2) begin
                  got = 1'b1;
                  break;
               end
            end
            chk("bp_fill", 32'(got), 32'd1);
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready),  32'd0);
            chk("bp_out_valid",    32'(out_valid), 32'd1);
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain("drain_backpressure");
      chk("bp_count", 32'(n_acc - base), 32'd4);

      // Reset with two words in flight.
      out_ready = 1'b0;
      send(8'h11, 8'h22, 1'b0, 1'b0);
      send(8'h33, 8'h44, 1'b0, 1'b0);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_sum",   32'(out_sum),   32'd0);
      chk("mid_rst_out_ovf",   32'(out_ovf),   32'd0);
      chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_no_stale", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      // Random valid/ready traffic.
      fired = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!in_valid || fired) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_cin   = 1'($urandom);
            in_sub   = 1'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         fired = in_valid && in_ready;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain("drain_random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
